// File: rtl/memory_sp_ctrl_pkg.sv
// Shared types and constants for the single-port memory controller.
package memory_pkg;

   typedef enum logic {INIT, RUN} state_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 2;
   localparam int unsigned BYTE_W     = 8;

   function automatic bit rd_lat_legal(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/memory_sp_ctrl_if.sv
// Request/response bus between the memory stage (master) and the controller (slave).
interface memory_sp_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 14
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_W/8-1:0]   req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/memory_sp_ctrl_ram.sv
// Raw single-port array with byte-lane write enables and a registered read.
module ram_sp_be
   import memory_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 14
) (
   input  logic                     clk_i,
   input  logic                     en_i,
   input  logic [DATA_W/BYTE_W-1:0] we_i,
   input  logic [ADDR_W-1:0]        addr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   output logic [DATA_W-1:0]        rdata_o
);

   localparam int unsigned NB    = DATA_W / BYTE_W;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Byte-lane writes; output register only loads on a read access
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (we_i[b]) begin
               mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
            end
         end
         if (we_i == '0) begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_sp_ctrl.sv
// Single-port memory controller: zero-fill sequencer, request muxing and read pipeline.
module memory_sp_ctrl
   import memory_pkg::*;
#(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned ADDR_W         = 14,
   parameter int unsigned RD_LAT         = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic            clka,
   input  logic            rsta_n,
   input  logic            clr,
   output logic            init_busy,
   memory_sp_ctrl_if.slave bus
);

   localparam int unsigned NB        = DATA_W / BYTE_W;
   localparam state_e      RST_STATE = CLEAR_ON_RESET ? INIT : RUN;

   if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
      $error("memory_sp_ctrl: RD_LAT must be 1 or 2");
   end
   if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
      $error("memory_sp_ctrl: DATA_W must be a multiple of 8");
   end

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                ready_q;
   logic                accept;
   logic                rd_acc;
   logic                ram_en;
   logic [NB-1:0]       ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;

   assign accept    = bus.req_valid && ready_q;
   assign rd_acc    = accept && (bus.req_we == '0);
   assign init_busy = (state_q == INIT);
   assign bus.req_ready = ready_q;

   // Next state, fill counter and RAM port mux (fill has the port during INIT)
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ram_en    = 1'b0;
      ram_we    = '0;
      ram_addr  = bus.req_addr;
      ram_wdata = bus.req_wdata;
      unique case (state_q)
         INIT: begin
            ram_en    = 1'b1;
            ram_we    = '1;
            ram_addr  = cnt_q;
            ram_wdata = '0;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
               state_d = RUN;
            end
         end
         RUN: begin
            ram_en = accept;
            ram_we = accept ? bus.req_we : '0;
            if (clr) begin
               state_d = INIT;
            end
         end
      endcase
   end

   // State, counter and registered ready (held low through reset in both modes)
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == RUN);
      end
   end

   ram_sp_be #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clka),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   if (RD_LAT == 1) begin : g_lat1
      logic vld_q;
      logic seen_q;

      // The RAM output register is the response register; it is not reset,
      // so data is masked to zero until the first read after reset.
      always_ff @(posedge clka or negedge rsta_n) begin
         if (!rsta_n) begin
            vld_q  <= 1'b0;
            seen_q <= 1'b0;
         end else begin
            vld_q  <= rd_acc;
            seen_q <= seen_q | rd_acc;
         end
      end

      assign bus.rsp_valid = vld_q;
      assign bus.rsp_rdata = seen_q ? ram_rdata : '0;
   end else begin : g_lat2
      logic              vld1_q, vld2_q;
      logic [DATA_W-1:0] rdata_q, rdata_d;

      // Second output stage loads only when a read leaves the RAM
      always_comb begin
         rdata_d = vld1_q ? ram_rdata : rdata_q;
      end

      // Valid shift register and output data register
      always_ff @(posedge clka or negedge rsta_n) begin
         if (!rsta_n) begin
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            rdata_q <= '0;
         end else begin
            vld1_q  <= rd_acc;
            vld2_q  <= vld1_q;
            rdata_q <= rdata_d;
         end
      end

      assign bus.rsp_valid = vld2_q;
      assign bus.rsp_rdata = rdata_q;
   end

endmodule

// File: tb/tb_memory_sp_ctrl.sv
// Bench: two controllers (RD_LAT 1 and 2) driven in lockstep, responses scoreboarded.
module tb_memory_sp_ctrl;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NV = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr   = 1'b0;
   logic busy1, busy2;

   memory_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
   memory_sp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

   memory_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)) u_lat1 (
      .clka(clk), .rsta_n(rst_n), .clr(clr), .init_busy(busy1), .bus(if1)
   );
   memory_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)) u_lat2 (
      .clka(clk), .rsta_n(rst_n), .clr(clr), .init_busy(busy2), .bus(if2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   typedef struct {
      logic [1:0]    we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   exp_t q1[$];
   exp_t q2[$];
   vec_t vecs [NV];
   int   errors = 0;
   int   checks = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // One request per call; reads push the expected word with its due cycle per instance.
   task automatic issue(input logic [1:0] we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp, input logic c);
      @(negedge clk);
      chk("req_ready", {30'd0, if1.req_ready, if2.req_ready}, 32'd3);
      if1.req_valid = 1'b1; if1.req_we = we; if1.req_addr = addr; if1.req_wdata = wdata;
      if2.req_valid = 1'b1; if2.req_we = we; if2.req_addr = addr; if2.req_wdata = wdata;
      clr = c;
      @(posedge clk); #1;
      if1.req_valid = 1'b0;
      if2.req_valid = 1'b0;
      clr = 1'b0;
      if (we == 2'b00) begin
         q1.push_back('{exp, cyc});
         q2.push_back('{exp, cyc + 1});
      end
   endtask

   // Counts init_busy cycles (ready must stay low); pulses clr at iteration clr_at.
   task automatic fill_watch(input int clr_at);
      int n1 = 0;
      int n2 = 0;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (!busy1 && !busy2) break;
         if (busy1) n1++;
         if (busy2) n2++;
         chk("ready_in_init", {30'd0, if1.req_ready && busy1, if2.req_ready && busy2}, 32'd0);
         clr = (i == clr_at);
         @(negedge clk);
      end
      clr = 1'b0;
      chk("fill_len_lat1", n1, 16);
      chk("fill_len_lat2", n2, 16);
      chk("ready_after_fill", {30'd0, if1.req_ready, if2.req_ready}, 32'd3);
   endtask

   task automatic drain();
      for (int i = 0; i < 10; i++) begin
         if (q1.size() == 0 && q2.size() == 0) break;
         @(negedge clk);
      end
      chk("drained", q1.size() + q2.size(), 0);
   endtask

   task automatic chk_reset_vals();
      @(negedge clk);
      chk("rst_ready", {30'd0, if1.req_ready, if2.req_ready}, 32'd0);
      chk("rst_valid", {30'd0, if1.rsp_valid, if2.rsp_valid}, 32'd0);
      chk("rst_rdata", {if1.rsp_rdata, if2.rsp_rdata}, 32'd0);
      chk("rst_busy", {30'd0, busy1, busy2}, 32'd3);
   endtask

   initial begin
      if1.req_valid = 1'b0; if1.req_we = '0; if1.req_addr = '0; if1.req_wdata = '0;
      if2.req_valid = 1'b0; if2.req_we = '0; if2.req_addr = '0; if2.req_wdata = '0;

      vecs[0]  = '{2'b11, 4'd2, 16'd420,  16'h0000};
      vecs[1]  = '{2'b11, 4'd4, 16'd69,   16'h0000};
      vecs[2]  = '{2'b11, 4'd7, 16'hABCD, 16'h0000};
      vecs[3]  = '{2'b10, 4'd7, 16'h1200, 16'h0000};
      vecs[4]  = '{2'b00, 4'd2, 16'h0000, 16'd420};
      vecs[5]  = '{2'b00, 4'd4, 16'h0000, 16'd69};
      vecs[6]  = '{2'b00, 4'd7, 16'h0000, 16'h12CD};
      vecs[7]  = '{2'b00, 4'd2, 16'h0000, 16'd420};
      vecs[8]  = '{2'b11, 4'd9, 16'h5A5A, 16'h0000};
      vecs[9]  = '{2'b00, 4'd9, 16'h0000, 16'h5A5A};
      vecs[10] = '{2'b01, 4'd9, 16'h00FF, 16'h0000};
      vecs[11] = '{2'b00, 4'd9, 16'h0000, 16'h5AFF};

      // Response monitor: every rsp_valid must match the head of its queue on its due cycle.
      fork
         begin
            exp_t e;
            forever begin
               @(negedge clk);
               if (rst_n) begin
                  if (if1.rsp_valid) begin
                     if (q1.size() == 0) chk("rsp1_unexpected", {31'd0, if1.rsp_valid}, 32'd0);
                     else begin
                        e = q1.pop_front();
                        chk("rsp1_data", {16'd0, if1.rsp_rdata}, {16'd0, e.data});
                        chk("rsp1_cycle", cyc, e.due);
                     end
                  end else if (q1.size() != 0 && cyc > q1[0].due) begin
                     e = q1.pop_front();
                     chk("rsp1_missing", {31'd0, if1.rsp_valid}, 32'd1);
                  end
                  if (if2.rsp_valid) begin
                     if (q2.size() == 0) chk("rsp2_unexpected", {31'd0, if2.rsp_valid}, 32'd0);
                     else begin
                        e = q2.pop_front();
                        chk("rsp2_data", {16'd0, if2.rsp_rdata}, {16'd0, e.data});
                        chk("rsp2_cycle", cyc, e.due);
                     end
                  end else if (q2.size() != 0 && cyc > q2[0].due) begin
                     e = q2.pop_front();
                     chk("rsp2_missing", {31'd0, if2.rsp_valid}, 32'd1);
                  end
               end
            end
         end
      join_none

      // Reset values, then fill after release
      repeat (3) @(posedge clk);
      chk_reset_vals();
      @(posedge clk); #1 rst_n = 1'b1;
      fill_watch(-1);

      // Whole array reads zero after the fill
      for (int a = 0; a < 16; a++) issue(2'b00, AW'(a), '0, 16'h0000, 1'b0);
      drain();

      // Table: full-word writes, byte lanes, back-to-back reads, write-then-read
      for (int i = 0; i < NV; i++) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0);
      drain();
      @(negedge clk);
      chk("rdata_hold", {if1.rsp_rdata, if2.rsp_rdata}, {16'h5AFF, 16'h5AFF});

      // clr with a concurrent read; second clr mid-fill must not extend it
      issue(2'b00, 4'd2, '0, 16'd420, 1'b1);
      fill_watch(8);
      drain();
      issue(2'b00, 4'd2, '0, 16'h0000, 1'b0);
      drain();

      // Reset at fill address 5
      issue(2'b11, 4'd5,  16'h7777, '0, 1'b0);
      issue(2'b11, 4'd12, 16'h3333, '0, 1'b0);
      issue(2'b00, 4'd12, '0, 16'h3333, 1'b0);
      drain();
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      chk_reset_vals();
      @(posedge clk); #1 rst_n = 1'b1;
      fill_watch(-1);
      issue(2'b00, 4'd5,  '0, 16'h0000, 1'b0);
      issue(2'b00, 4'd12, '0, 16'h0000, 1'b0);
      drain();

      // Reset with a read in flight: no response may appear afterwards
      issue(2'b11, 4'd3, 16'hBEEF, '0, 1'b0);
      issue(2'b00, 4'd3, '0, 16'hBEEF, 1'b0);
      rst_n = 1'b0;
      q1.delete();
      q2.delete();
      chk_reset_vals();
      @(posedge clk); #1 rst_n = 1'b1;
      fill_watch(-1);
      issue(2'b00, 4'd3, '0, 16'h0000, 1'b0);
      drain();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
